// File: rtl/gpio_cmd_regfile_if.sv
// GPIO command/readback word pair between the microcontroller and the register file.
interface gpio_cmd_regfile_if;
  logic [31:0] i_gpio_to_regf;
  logic [31:0] o_regf_to_gpio;

  modport master (output i_gpio_to_regf, input o_regf_to_gpio);
  modport slave  (input i_gpio_to_regf, output o_regf_to_gpio);
endinterface

// File: rtl/gpio_cmd_regfile.sv
// Command-decoded register file: edge-triggered command accept, self-timed soft
// reset pulse, atomic counter snapshot and registered readback with status.
module gpio_cmd_regfile #(
  parameter logic signed [7:0] SIGMA_INIT    = 8'sh1C,
  parameter int unsigned       RAM_DEPTH     = 32768,
  parameter int unsigned       NUM_CNT       = 4,
  parameter int unsigned       NBT_CNT       = 64,
  parameter int unsigned       RST_PULSE_LEN = 16,
  parameter logic [7:0]        VERSION       = 8'h02,
  localparam int unsigned      AW            = $clog2(RAM_DEPTH)
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  gpio_cmd_regfile_if.slave          gpio,
  input  logic [NUM_CNT*NBT_CNT-1:0] i_cnt,
  input  logic [31:0]                i_data_ram_for_read,
  output logic                       o_rst_soft,
  output logic                       o_en_rx_soft,
  output logic signed [7:0]          o_sigma,
  output logic [1:0]                 o_sel_ch_taps,
  output logic [2:0]                 o_data_sel_for_log,
  output logic                       o_en_write,
  output logic                       o_en_read_from_ram,
  output logic [AW-1:0]              o_read_adrs
);

  localparam int unsigned  WPC      = NBT_CNT / 32;
  localparam int unsigned  RCW      = $clog2(RST_PULSE_LEN + 1);
  localparam logic [RCW-1:0] RST_LOAD = RCW'(RST_PULSE_LEN);
  localparam logic [7:0]   NUM8     = 8'(NUM_CNT);
  localparam logic [7:0]   WPC8     = 8'(WPC);

  typedef enum logic [7:0] {
    OP_SOFT_RST  = 8'h01,
    OP_RX_EN     = 8'h02,
    OP_SIGMA     = 8'h03,
    OP_TAPS      = 8'h04,
    OP_LOG       = 8'h06,
    OP_RAM_RD    = 8'h07,
    OP_SNAP      = 8'h08,
    OP_CNT_RD    = 8'h09,
    OP_STATUS_RD = 8'h0A,
    OP_CLR       = 8'h0B
  } op_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_RAM,
    SRC_CNT,
    SRC_STATUS
  } src_t;

  logic                       strb_d;
  logic                       accept;
  logic [7:0]                 opcode;
  logic [RCW-1:0]             rst_cnt;
  logic [NUM_CNT*NBT_CNT-1:0] shadow;
  logic                       snap_valid;
  logic                       bad_op;
  logic                       bad_idx;
  logic [7:0]                 cnt_idx;
  logic [7:0]                 word_idx;
  src_t                       src_q;
  src_t                       src_d;
  logic [31:0]                cnt_word;
  logic [31:0]                rd_next;

  assign opcode     = gpio.i_gpio_to_regf[31:24];
  assign accept     = gpio.i_gpio_to_regf[23] & ~strb_d;
  assign o_rst_soft = (rst_cnt != '0);

  // Strobe edge detect, soft-reset timer, control registers, shadows and sticky flags.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      strb_d             <= 1'b1;
      rst_cnt            <= RST_LOAD;
      o_en_rx_soft       <= 1'b1;
      o_sigma            <= SIGMA_INIT;
      o_sel_ch_taps      <= '0;
      o_data_sel_for_log <= '0;
      o_en_write         <= 1'b0;
      o_en_read_from_ram <= 1'b0;
      o_read_adrs        <= '0;
      shadow             <= '0;
      snap_valid         <= 1'b0;
      bad_op             <= 1'b0;
      bad_idx            <= 1'b0;
      cnt_idx            <= '0;
      word_idx           <= '0;
    end else begin
      strb_d <= gpio.i_gpio_to_regf[23];

      if (accept && opcode == OP_SOFT_RST) begin
        rst_cnt <= RST_LOAD;
      end else if (rst_cnt != '0) begin
        rst_cnt <= rst_cnt - RCW'(1);
      end

      if (accept) begin
        case (opcode)
          OP_SOFT_RST:  begin end
          OP_RX_EN:     o_en_rx_soft <= gpio.i_gpio_to_regf[0];
          OP_SIGMA:     o_sigma <= gpio.i_gpio_to_regf[7:0];
          OP_TAPS:      o_sel_ch_taps <= gpio.i_gpio_to_regf[1:0];
          OP_LOG: begin
            o_data_sel_for_log <= gpio.i_gpio_to_regf[2:0];
            o_en_write         <= gpio.i_gpio_to_regf[3];
          end
          OP_RAM_RD: begin
            o_read_adrs        <= gpio.i_gpio_to_regf[AW-1:0];
            o_en_read_from_ram <= gpio.i_gpio_to_regf[16];
          end
          OP_SNAP: begin
            shadow     <= i_cnt;
            snap_valid <= 1'b1;
          end
          OP_CNT_RD: begin
            cnt_idx  <= gpio.i_gpio_to_regf[15:8];
            word_idx <= gpio.i_gpio_to_regf[7:0];
            if (gpio.i_gpio_to_regf[15:8] >= NUM8 || gpio.i_gpio_to_regf[7:0] >= WPC8) begin
              bad_idx <= 1'b1;
            end
          end
          OP_STATUS_RD: begin end
          OP_CLR: begin
            bad_op     <= 1'b0;
            bad_idx    <= 1'b0;
            snap_valid <= 1'b0;
          end
          default:      bad_op <= 1'b1;
        endcase
      end
    end
  end

  // Readback source state register.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      src_q <= SRC_NONE;
    end else begin
      src_q <= src_d;
    end
  end

  // Readback source selection from accepted read commands.
  always_comb begin
    src_d = src_q;
    if (accept) begin
      case (opcode)
        OP_RAM_RD:    src_d = gpio.i_gpio_to_regf[16] ? SRC_RAM : SRC_NONE;
        OP_CNT_RD:    src_d = SRC_CNT;
        OP_STATUS_RD: src_d = SRC_STATUS;
        default:      src_d = src_q;
      endcase
    end
  end

  // Shadow word select; an index pair that matches no slot yields zero.
  always_comb begin
    cnt_word = '0;
    for (int unsigned n = 0; n < NUM_CNT; n++) begin
      for (int unsigned w = 0; w < WPC; w++) begin
        if (cnt_idx == 8'(n) && word_idx == 8'(w)) begin
          cnt_word = shadow[n*NBT_CNT + w*32 +: 32];
        end
      end
    end
  end

  // Readback word mux for the current source.
  always_comb begin
    rd_next = '0;
    case (src_q)
      SRC_NONE:   rd_next = '0;
      SRC_RAM:    rd_next = i_data_ram_for_read;
      SRC_CNT:    rd_next = cnt_word;
      SRC_STATUS: rd_next = {VERSION, NUM8, WPC8, 4'b0, bad_op, bad_idx, snap_valid, o_rst_soft};
      default:    rd_next = '0;
    endcase
  end

  // Registered readback.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gpio.o_regf_to_gpio <= '0;
    end else begin
      gpio.o_regf_to_gpio <= rd_next;
    end
  end

endmodule
